// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART frame controller: start-of-frame
//   marker and the frame parser state enumeration.
package uart_pkg;

    localparam logic [7:0] SOF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_HOLD
    } frm_state_t;

endpackage

// File: rtl/uart_frame_timer.sv
// uart_frame_timer
//   Inter-byte silence timer. Counts s_tick strobes while enabled and
//   flags expiry on the TO_TICKS-th tick.
//   Ports:
//     clk, reset  - clock, async active-high reset
//     s_tick      - 16x baud sample strobe
//     clr         - synchronous clear (wins over counting and expiry)
//     en          - count enable
//     expired     - combinational: this cycle's tick reaches TO_TICKS
module uart_frame_timer #(
    parameter int TO_TICKS = 640
) (
    input  logic clk,
    input  logic reset,
    input  logic s_tick,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TO_TICKS + 1);

    logic [CW-1:0] r_cnt;

    // A byte arriving on the terminal tick clears the count instead of
    // expiring, so clr masks expiry.
    assign expired = en && !clr && s_tick && (r_cnt == CW'(TO_TICKS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (clr || expired)
            r_cnt <= '0;
        else if (en && s_tick)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
//   Parses SOF/ADDR/LEN/payload/CHK frames from a UART receiver byte
//   stream, verifies the XOR checksum and holds the frame for a
//   valid/ready consumer.
//   Ports:
//     clk, reset          - clock, async active-high reset
//     s_tick              - 16x baud strobe (drives silence timeout)
//     rx_done_tick/rx_data- received byte strobe and value
//     frm_valid/frm_ready - frame handshake
//     frm_addr, frm_len   - held frame header
//     rd_idx/rd_data      - combinational payload read port
//     err_chk/len/to/ovr  - one-cycle error pulses (registered)
//     busy                - parser not idle
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int TO_TICKS = 640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       frm_valid,
    input  logic       frm_ready,
    output logic [7:0] frm_addr,
    output logic [7:0] frm_len,
    input  logic [7:0] rd_idx,
    output logic [7:0] rd_data,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_to,
    output logic       err_ovr,
    output logic       busy
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    frm_state_t r_state, w_next;

    logic [7:0] r_addr, r_len, r_chk, r_idx;
    logic [7:0] r_buf [MAX_LEN];
    logic       r_err_chk, r_err_len, r_err_to, r_err_ovr;
    logic       w_err_chk, w_err_len, w_err_to, w_err_ovr;
    logic       w_expired, w_tmr_en, w_tmr_clr;

    assign w_tmr_en  = (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                       (r_state == ST_DATA) || (r_state == ST_CHK);
    assign w_tmr_clr = rx_done_tick || !w_tmr_en;

    uart_frame_timer #(.TO_TICKS(TO_TICKS)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .s_tick  (s_tick),
        .clr     (w_tmr_clr),
        .en      (w_tmr_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_err_chk = 1'b0;
        w_err_len = 1'b0;
        w_err_to  = 1'b0;
        w_err_ovr = 1'b0;
        case (r_state)
            ST_IDLE: if (rx_done_tick && rx_data == SOF) w_next = ST_ADDR;
            ST_ADDR: if (rx_done_tick) w_next = ST_LEN;
            ST_LEN: begin
                if (rx_done_tick) begin
                    if (rx_data > 8'(MAX_LEN)) begin
                        w_err_len = 1'b1;
                        w_next    = ST_IDLE;
                    end else if (rx_data == 8'h00) begin
                        w_next = ST_CHK;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: if (rx_done_tick && r_idx == r_len - 8'd1) w_next = ST_CHK;
            ST_CHK: begin
                if (rx_done_tick) begin
                    if (rx_data == r_chk) begin
                        w_next = ST_HOLD;
                    end else begin
                        w_err_chk = 1'b1;
                        w_next    = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // Bytes during HOLD are dropped, including the handshake cycle.
                w_err_ovr = rx_done_tick;
                if (frm_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // Expiry is already masked by rx_done_tick, so this never
        // overrides a byte-driven transition or a second error.
        if (w_expired) begin
            w_err_to = 1'b1;
            w_next   = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= 8'h00;
            r_len  <= 8'h00;
            r_chk  <= 8'h00;
            r_idx  <= 8'h00;
        end else if (rx_done_tick) begin
            case (r_state)
                ST_ADDR: begin
                    r_addr <= rx_data;
                    r_chk  <= rx_data;
                end
                ST_LEN: begin
                    r_chk <= r_chk ^ rx_data;
                    r_idx <= 8'h00;
                    // Oversized lengths are never latched so the read
                    // guard below always stays inside the buffer.
                    if (rx_data <= 8'(MAX_LEN)) r_len <= rx_data;
                end
                ST_DATA: begin
                    r_chk <= r_chk ^ rx_data;
                    r_idx <= r_idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Payload storage: not reset, not cleared between frames.
    always_ff @(posedge clk) begin
        if (rx_done_tick && r_state == ST_DATA)
            r_buf[r_idx[IW-1:0]] <= rx_data;
    end

    // Errors are registered so none can land on the frm_valid rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_chk <= 1'b0;
            r_err_len <= 1'b0;
            r_err_to  <= 1'b0;
            r_err_ovr <= 1'b0;
        end else begin
            r_err_chk <= w_err_chk;
            r_err_len <= w_err_len;
            r_err_to  <= w_err_to;
            r_err_ovr <= w_err_ovr;
        end
    end

    assign frm_valid = (r_state == ST_HOLD);
    assign busy      = (r_state != ST_IDLE);
    assign frm_addr  = r_addr;
    assign frm_len   = r_len;
    assign rd_data   = (rd_idx < r_len) ? r_buf[rd_idx[IW-1:0]] : 8'h00;
    assign err_chk   = r_err_chk;
    assign err_len   = r_err_len;
    assign err_to    = r_err_to;
    assign err_ovr   = r_err_ovr;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
module tb_uart_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       frm_valid;
    logic       frm_ready = 1'b0;
    logic [7:0] frm_addr, frm_len;
    logic [7:0] rd_idx = 8'h00;
    logic [7:0] rd_data;
    logic       err_chk, err_len, err_to, err_ovr, busy;

    int errors = 0;
    int checks = 0;

    uart_frame_ctrl #(.MAX_LEN(16), .TO_TICKS(640)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .frm_valid(frm_valid), .frm_ready(frm_ready),
        .frm_addr(frm_addr), .frm_len(frm_len),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .err_chk(err_chk), .err_len(err_len), .err_to(err_to), .err_ovr(err_ovr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Each call consumes one clock; outputs are sampled 1 time unit after the edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            s_tick = 1'b1;
            @(posedge clk); #1;
            s_tick = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({frm_valid, busy, err_chk, err_len, err_to, err_ovr} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 000000", {frm_valid, busy, err_chk, err_len, err_to, err_ovr}); end
        checks++; if ({frm_addr, frm_len, rd_data} !== 24'h0) begin
            errors++; $display("FAIL reset_fields got %h exp 000000", {frm_addr, frm_len, rd_data}); end
        reset = 1'b0;
        idle_cycle();
    endtask

    task automatic test_good_frame();
        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33});
        checks++; if (frm_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL good_pre_chk got valid=%b busy=%b exp valid=0 busy=1", frm_valid, busy); end
        // 10^03^11^22^33 = 13
        send_byte(8'h13);
        checks++; if (frm_valid !== 1'b1) begin
            errors++; $display("FAIL good_valid got %b exp 1", frm_valid); end
        checks++; if (frm_addr !== 8'h10 || frm_len !== 8'd3) begin
            errors++; $display("FAIL good_hdr got addr=%h len=%0d exp addr=10 len=3", frm_addr, frm_len); end
        rd_idx = 8'd0; #1;
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL good_rd0 got %h exp 11", rd_data); end
        rd_idx = 8'd1; #1;
        checks++; if (rd_data !== 8'h22) begin errors++; $display("FAIL good_rd1 got %h exp 22", rd_data); end
        rd_idx = 8'd2; #1;
        checks++; if (rd_data !== 8'h33) begin errors++; $display("FAIL good_rd2 got %h exp 33", rd_data); end
        rd_idx = 8'd3; #1;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL good_rd3 got %h exp 00", rd_data); end
        checks++; if ({err_chk, err_len, err_to, err_ovr} !== 4'b0) begin
            errors++; $display("FAIL good_noerr got %b exp 0000", {err_chk, err_len, err_to, err_ovr}); end
        frm_ready = 1'b1;
        idle_cycle();
        frm_ready = 1'b0;
        checks++; if (frm_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL good_release got valid=%b busy=%b exp 0 0", frm_valid, busy); end
    endtask

    task automatic test_zero_len();
        send_seq('{8'hA5, 8'h20, 8'h00, 8'h20});
        checks++; if (frm_valid !== 1'b1 || frm_len !== 8'd0 || frm_addr !== 8'h20) begin
            errors++; $display("FAIL zero_len got valid=%b len=%0d addr=%h exp 1 0 20", frm_valid, frm_len, frm_addr); end
        rd_idx = 8'd0; #1;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL zero_len_rd got %h exp 00", rd_data); end
        frm_ready = 1'b1; idle_cycle(); frm_ready = 1'b0;
        send_seq('{8'hA5, 8'h20, 8'h00, 8'h21});
        checks++; if (err_chk !== 1'b1 || frm_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bad_chk got err_chk=%b valid=%b busy=%b exp 1 0 0", err_chk, frm_valid, busy); end
        idle_cycle();
        checks++; if (err_chk !== 1'b0 || frm_valid !== 1'b0) begin
            errors++; $display("FAIL bad_chk_after got err_chk=%b valid=%b exp 0 0", err_chk, frm_valid); end
    endtask

    task automatic test_len_err();
        send_seq('{8'hA5, 8'h10, 8'h11});
        checks++; if (err_len !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL len_err got err_len=%b busy=%b exp 1 0", err_len, busy); end
        checks++; if ({err_chk, err_to, err_ovr} !== 3'b0) begin
            errors++; $display("FAIL len_err_only got %b exp 000", {err_chk, err_to, err_ovr}); end
        idle_cycle();
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL len_err_pulse got %b exp 0", err_len); end
        // 07^01^AB = AD
        send_seq('{8'hA5, 8'h07, 8'h01, 8'hAB, 8'hAD});
        rd_idx = 8'd0; #1;
        checks++; if (frm_valid !== 1'b1 || frm_len !== 8'd1 || rd_data !== 8'hAB) begin
            errors++; $display("FAIL len_recover got valid=%b len=%0d rd=%h exp 1 1 ab", frm_valid, frm_len, rd_data); end
        frm_ready = 1'b1; idle_cycle(); frm_ready = 1'b0;
    endtask

    task automatic test_timeout();
        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11});
        tick_n(639);
        checks++; if (busy !== 1'b1 || err_to !== 1'b0) begin
            errors++; $display("FAIL to_639 got busy=%b err_to=%b exp 1 0", busy, err_to); end
        s_tick = 1'b1;
        @(posedge clk); #1;
        s_tick = 1'b0;
        checks++; if (err_to !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL to_640 got err_to=%b busy=%b exp 1 0", err_to, busy); end
        idle_cycle();
        checks++; if (err_to !== 1'b0) begin errors++; $display("FAIL to_pulse got %b exp 0", err_to); end
        // Byte on the terminal tick wins.
        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11});
        tick_n(639);
        s_tick = 1'b1;
        send_byte(8'h22);
        s_tick = 1'b0;
        checks++; if (err_to !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_coincide got err_to=%b busy=%b exp 0 1", err_to, busy); end
        tick_n(639);
        checks++; if (busy !== 1'b1 || err_to !== 1'b0) begin
            errors++; $display("FAIL to_cleared got busy=%b err_to=%b exp 1 0", busy, err_to); end
        send_seq('{8'h33, 8'h13});
        rd_idx = 8'd1; #1;
        checks++; if (frm_valid !== 1'b1 || rd_data !== 8'h22) begin
            errors++; $display("FAIL to_complete got valid=%b rd1=%h exp 1 22", frm_valid, rd_data); end
        frm_ready = 1'b1; idle_cycle(); frm_ready = 1'b0;
    endtask

    task automatic test_overrun();
        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});
        idle_cycle();
        send_byte(8'h55);
        rd_idx = 8'd1; #1;
        checks++; if (err_ovr !== 1'b1 || frm_valid !== 1'b1) begin
            errors++; $display("FAIL ovr got err_ovr=%b valid=%b exp 1 1", err_ovr, frm_valid); end
        checks++; if (frm_addr !== 8'h10 || frm_len !== 8'd3 || rd_data !== 8'h22) begin
            errors++; $display("FAIL ovr_stable got addr=%h len=%0d rd1=%h exp 10 3 22", frm_addr, frm_len, rd_data); end
        frm_ready = 1'b1;
        idle_cycle();
        frm_ready = 1'b0;
        checks++; if (busy !== 1'b0 || frm_valid !== 1'b0 || err_ovr !== 1'b0) begin
            errors++; $display("FAIL ovr_release got busy=%b valid=%b err_ovr=%b exp 0 0 0", busy, frm_valid, err_ovr); end
    endtask

    task automatic test_back_to_back();
        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13});
        // Byte on the handshake cycle is dropped with an overrun.
        frm_ready = 1'b1;
        send_byte(8'hA5);
        frm_ready = 1'b0;
        checks++; if (err_ovr !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_hs_ovr got err_ovr=%b busy=%b exp 1 0", err_ovr, busy); end
        send_seq('{8'hA5, 8'h20, 8'h00, 8'h20});
        checks++; if (frm_valid !== 1'b1 || frm_addr !== 8'h20 || frm_len !== 8'd0) begin
            errors++; $display("FAIL b2b_next got valid=%b addr=%h len=%0d exp 1 20 0", frm_valid, frm_addr, frm_len); end
        frm_ready = 1'b1; idle_cycle(); frm_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11});
        #2 reset = 1'b1;
        #1;
        checks++; if ({frm_valid, busy, err_chk, err_len, err_to, err_ovr} !== 6'b0 ||
                      {frm_addr, frm_len} !== 16'h0) begin
            errors++; $display("FAIL mid_reset got flags=%b addr=%h len=%h exp 0", {frm_valid, busy, err_chk, err_len, err_to, err_ovr}, frm_addr, frm_len); end
        @(posedge clk); #1;
        reset = 1'b0;
        send_seq('{8'h00, 8'hFF});
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL garbage got busy=%b exp 0", busy); end
        send_seq('{8'hA5, 8'h20, 8'h00, 8'h20});
        checks++; if (frm_valid !== 1'b1 || frm_addr !== 8'h20) begin
            errors++; $display("FAIL post_reset got valid=%b addr=%h exp 1 20", frm_valid, frm_addr); end
        frm_ready = 1'b1; idle_cycle(); frm_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_zero_len();
        test_len_err();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
